ad9866_gain_sequencer: RTL and testbench
========================================

// Module: ad9866_gain_sequencer
// PURPOSE
// Upstream feeder for the AD9866 SPI controller. Watches host RX/TX gain codes, debounces changes and
// issues one-at-a-time ext_rx_rqst/ext_tx_rqst requests with held gain values. Never asserts both
// requests together, holds each request until the SPI frame starts, and respects an init holdoff.
// PARAMETERS
// HOLDOFF_CYCLES  2048  cycles after reset release before any request (covers SPI init sequence)
// STABLE_CYCLES   16    cycles a changed gain code must stay constant before it is queued
// TIMEOUT_CYCLES  255   max cycles a request waits for sen_n low before being abandoned
// GAP_CYCLES      4     idle cycles enforced after sen_n returns high, before next request
// PORTS
// clk           in   1  system clock, shared with SPI controller
// reset_n       in   1  asynchronous, active-low reset
// host_rx_gain  in   6  requested RX gain code from host command decoder
// host_tx_gain  in   6  requested TX gain code from host command decoder
// force_update  in   1  1-cycle pulse: queue both RX and TX regardless of change
// sen_n         in   1  SPI chip-enable from SPI controller (low = frame in progress)
// ext_rx_rqst   out  1  RX gain write request to SPI controller
// rx_gain       out  6  RX gain code presented with ext_rx_rqst
// ext_tx_rqst   out  1  TX gain write request to SPI controller
// tx_gain       out  6  TX gain code presented with ext_tx_rqst
// busy          out  1  high in any state other than IDLE
// timeout_err   out  1  sticky; set on request timeout, cleared only by reset
// BEHAVIOUR
// - Reset: all outputs 0; rx_gain/tx_gain 0; pending flags clear; stability counters 0; state HOLDOFF.
// - All outputs registered. ext_rx_rqst and ext_tx_rqst are mutually exclusive on every cycle.
// - Change detect (per channel): shadow register vs host input; on mismatch restart stability count;
//   when input equal to itself for STABLE_CYCLES consecutive cycles and differs from last-sent value,
//   set pending and capture code. New change while pending: recapture after re-stabilising; pending kept.
// - force_update sets both pending flags using current shadow codes; ignored during HOLDOFF (both
//   pendings are set automatically at HOLDOFF exit so post-init gains always get written).
// - States: HOLDOFF -> IDLE after HOLDOFF_CYCLES. IDLE: if rx pending -> REQ_RX, else tx pending
//   -> REQ_TX; if both pending, alternate, starting with RX after reset (last-served bit).
// - REQ_x: drive x_gain with captured code, assert ext_x_rqst; only sample sen_n low as start.
//   On first sampled sen_n==0: deassert request next cycle, clear that pending flag (unless the code
//   recaptured since issue), -> XFER. If TIMEOUT_CYCLES elapse with sen_n high: deassert, set
//   timeout_err, keep pending, -> GAP.
// - x_gain value frozen from request assertion until XFER exit; never changes while request high.
// - XFER: wait for sen_n==1, -> GAP. GAP: count GAP_CYCLES, -> IDLE.
// - Latency: stable change to request assertion = STABLE_CYCLES+2 cycles when IDLE.
// - sen_n already low on entry to REQ_x (foreign frame): hold request; treat only a 1->0 edge
//   seen during REQ_x as acceptance.
// - reset_n asserted mid-operation: immediate return to reset values, request dropped same instant.
// TESTING
// - Reset release, host_rx_gain=6'h20, host_tx_gain=6'h10: no request during HOLDOFF; then RX request
//   rx_gain=6'h20, then TX tx_gain=6'h10, never both high.
// - IDLE, host_rx_gain 6'h05->6'h2A stable: request exactly STABLE_CYCLES+2 cycles later, rx_gain=6'h2A.
// - Glitch host_tx_gain 6'h10->6'h11->6'h10 within 3 cycles: no TX request issued.
// - Model SPI slave holding sen_n high forever: request drops after TIMEOUT_CYCLES=255, timeout_err=1,
//   request retried after GAP.
// - Both channels change same cycle, then force_update mid-XFER: order RX,TX,RX,TX alternating;
//   gains stable while requests high.
// - reset_n low during REQ_TX: ext_tx_rqst=0 asynchronously, state HOLDOFF on release.

Source files
------------

// File: rtl/ad9866_gain_sequencer.sv
// Gain-change sequencer feeding the AD9866 SPI controller: debounces host RX/TX gain codes and
// issues one request at a time, holding each until the SPI frame it triggers actually starts.
module ad9866_gain_sequencer #(
    parameter int HOLDOFF_CYCLES = 2048,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] host_rx_gain,
    input  logic [5:0] host_tx_gain,
    input  logic       force_update,
    input  logic       sen_n,
    output logic       ext_rx_rqst,
    output logic [5:0] rx_gain,
    output logic       ext_tx_rqst,
    output logic [5:0] tx_gain,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [2:0] S_HOLDOFF = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_REQ_RX  = 3'd2;
    localparam logic [2:0] S_REQ_TX  = 3'd3;
    localparam logic [2:0] S_XFER    = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    localparam int CNT_MAX = (HOLDOFF_CYCLES > TIMEOUT_CYCLES)
                           ? ((HOLDOFF_CYCLES > GAP_CYCLES) ? HOLDOFF_CYCLES : GAP_CYCLES)
                           : ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    logic [2:0]      state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            cur_ch_reg, cur_ch_next;   // channel being / last served: 0 = RX, 1 = TX
    logic            seen_high_reg, seen_high_next;
    logic            timeout_set;
    logic            ext_rx_rqst_reg, ext_tx_rqst_reg, busy_reg, timeout_err_reg;
    logic [5:0]      rx_gain_reg, tx_gain_reg;

    logic [1:0][5:0] host_code;
    logic [1:0][5:0] issued_code;
    logic [1:0][5:0] capture_code;
    logic [1:0]      pending;
    logic            hold_exit, force_evt, in_req, accept;

    assign host_code   = {host_tx_gain, host_rx_gain};
    assign issued_code = {tx_gain_reg, rx_gain_reg};

    assign hold_exit = (state_reg == S_HOLDOFF) && (cnt_reg == CW'(HOLDOFF_CYCLES - 1));
    assign force_evt = force_update && (state_reg != S_HOLDOFF);
    assign in_req    = (state_reg == S_REQ_RX) || (state_reg == S_REQ_TX);
    // Only a high-to-low transition observed while requesting counts as our frame starting.
    assign accept    = in_req && !sen_n && seen_high_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [5:0]    shadow_reg;
            logic [SW-1:0] stab_cnt_reg;
            logic [5:0]    capture_reg;
            logic [5:0]    sent_reg;
            logic          pending_reg;
            logic [5:0]    target;
            logic          stable_evt;
            logic          accept_ch;

            // Compare against the queued code while pending so a later change is recaptured.
            assign target     = pending_reg ? capture_reg : sent_reg;
            assign stable_evt = (host_code[gi] == shadow_reg)
                              && (stab_cnt_reg == SW'(STABLE_CYCLES - 1))
                              && (shadow_reg != target);
            assign accept_ch  = accept && (cur_ch_reg == gi[0]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg   <= '0;
                    stab_cnt_reg <= '0;
                    capture_reg  <= '0;
                    sent_reg     <= '0;
                    pending_reg  <= 1'b0;
                end else begin
                    if (host_code[gi] != shadow_reg) begin
                        shadow_reg   <= host_code[gi];
                        stab_cnt_reg <= '0;
                    end else if (stab_cnt_reg != SW'(STABLE_CYCLES)) begin
                        stab_cnt_reg <= stab_cnt_reg + 1'b1;
                    end
                    if (stable_evt || hold_exit || force_evt) begin
                        capture_reg <= shadow_reg;
                        pending_reg <= 1'b1;
                    end else if (accept_ch && (capture_reg == issued_code[gi])) begin
                        pending_reg <= 1'b0;
                    end
                    if (accept_ch) begin
                        sent_reg <= issued_code[gi];
                    end
                end
            end

            assign capture_code[gi] = capture_reg;
            assign pending[gi]      = pending_reg;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cur_ch_next    = cur_ch_reg;
        seen_high_next = seen_high_reg;
        timeout_set    = 1'b0;
        case (state_reg)
            S_HOLDOFF: begin
                if (hold_exit) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_IDLE: begin
                cnt_next       = '0;
                seen_high_next = 1'b0;
                if (pending[0] && (!pending[1] || cur_ch_reg)) begin
                    state_next  = S_REQ_RX;
                    cur_ch_next = 1'b0;
                end else if (pending[1]) begin
                    state_next  = S_REQ_TX;
                    cur_ch_next = 1'b1;
                end
            end
            S_REQ_RX, S_REQ_TX: begin
                seen_high_next = seen_high_reg | sen_n;
                if (accept) begin
                    state_next = S_XFER;
                end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_next  = S_GAP;
                    cnt_next    = '0;
                    timeout_set = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_XFER: begin
                if (sen_n) begin
                    state_next = S_GAP;
                    cnt_next   = '0;
                end
            end
            S_GAP: begin
                if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_HOLDOFF;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_HOLDOFF;
            cnt_reg         <= '0;
            cur_ch_reg      <= 1'b1;
            seen_high_reg   <= 1'b0;
            ext_rx_rqst_reg <= 1'b0;
            ext_tx_rqst_reg <= 1'b0;
            rx_gain_reg     <= '0;
            tx_gain_reg     <= '0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cur_ch_reg      <= cur_ch_next;
            seen_high_reg   <= seen_high_next;
            ext_rx_rqst_reg <= (state_next == S_REQ_RX);
            ext_tx_rqst_reg <= (state_next == S_REQ_TX);
            busy_reg        <= (state_next != S_IDLE);
            timeout_err_reg <= timeout_err_reg | timeout_set;
            // Gains are loaded only when a request is raised, so they stay frozen through XFER.
            if ((state_reg == S_IDLE) && (state_next == S_REQ_RX)) begin
                rx_gain_reg <= capture_code[0];
            end
            if ((state_reg == S_IDLE) && (state_next == S_REQ_TX)) begin
                tx_gain_reg <= capture_code[1];
            end
        end
    end

    assign ext_rx_rqst = ext_rx_rqst_reg;
    assign ext_tx_rqst = ext_tx_rqst_reg;
    assign rx_gain     = rx_gain_reg;
    assign tx_gain     = tx_gain_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_ad9866_gain_sequencer.sv
// Directed bench for ad9866_gain_sequencer: vector table for single-channel changes plus
// hand-written sequences for holdoff, glitch, timeout, alternation with force and async reset.
module tb_ad9866_gain_sequencer;

    localparam int HOLD    = 2048;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 255;
    localparam int GAP     = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] host_rx_gain = 6'h00;
    logic [5:0] host_tx_gain = 6'h00;
    logic       force_update = 1'b0;
    logic       sen_n = 1'b1;
    logic       ext_rx_rqst, ext_tx_rqst, busy, timeout_err;
    logic [5:0] rx_gain, tx_gain;

    int checks = 0;
    int errors = 0;
    bit slave_on = 1'b0;

    typedef struct {
        bit         is_tx;
        logic [5:0] gain;
    } req_t;
    req_t q[$];

    typedef struct {
        bit         is_tx;
        logic [5:0] code;
        bit         exp_req;
        logic [5:0] exp_gain;
    } vec_t;
    vec_t vt[6];

    always #5 clk = ~clk;

    ad9866_gain_sequencer #(
        .HOLDOFF_CYCLES(HOLD),
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_rx_gain(host_rx_gain),
        .host_tx_gain(host_tx_gain),
        .force_update(force_update),
        .sen_n       (sen_n),
        .ext_rx_rqst (ext_rx_rqst),
        .rx_gain     (rx_gain),
        .ext_tx_rqst (ext_tx_rqst),
        .tx_gain     (tx_gain),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic chk_q(input int idx, input bit exp_tx, input logic [5:0] exp_gain);
        if (idx >= q.size()) begin
            chk($sformatf("req%0d_present", idx), q.size(), idx + 1);
        end else begin
            chk($sformatf("req%0d_channel", idx), int'(q[idx].is_tx), int'(exp_tx));
            chk($sformatf("req%0d_gain", idx), int'(q[idx].gain), int'(exp_gain));
        end
    endtask

    // SPI slave model: answers a request two cycles later with an 8-cycle frame.
    initial begin
        forever begin
            @(negedge clk);
            if (slave_on && (ext_rx_rqst || ext_tx_rqst)) begin
                repeat (2) @(negedge clk);
                sen_n = 1'b0;
                repeat (8) @(negedge clk);
                sen_n = 1'b1;
            end
        end
    end

    // Request monitor: logs each request rising edge, checks exclusivity and gain stability.
    initial begin
        bit         prev_rx = 1'b0, prev_tx = 1'b0;
        logic [5:0] prev_rxg = '0, prev_txg = '0;
        forever begin
            @(negedge clk);
            if (ext_rx_rqst || ext_tx_rqst) begin
                checks++;
                if (ext_rx_rqst && ext_tx_rqst) begin
                    errors++;
                    $display("FAIL exclusive: got both requests high expected at most one");
                end
            end
            if (ext_rx_rqst && !prev_rx) q.push_back('{1'b0, rx_gain});
            if (ext_tx_rqst && !prev_tx) q.push_back('{1'b1, tx_gain});
            if ((ext_rx_rqst && prev_rx && rx_gain != prev_rxg) ||
                (ext_tx_rqst && prev_tx && tx_gain != prev_txg)) begin
                checks++;
                errors++;
                $display("FAIL gain_stable: gain changed while request high");
            end
            prev_rx  = ext_rx_rqst;
            prev_tx  = ext_tx_rqst;
            prev_rxg = rx_gain;
            prev_txg = tx_gain;
        end
    end

    task automatic wait_idle();
        int quiet = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            quiet = (!busy && sen_n) ? quiet + 1 : 0;
            if (quiet == 3) return;
        end
        chk("wait_idle_bound", 0, 1);
    endtask

    task automatic wait_req(input bit is_tx, input int limit, output int lat);
        lat = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (is_tx ? ext_tx_rqst : ext_rx_rqst) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic check_holdoff();
        bit quiet = 1'b1;
        for (int n = 0; n < HOLD - 8; n++) begin
            @(posedge clk);
            #1;
            if (ext_rx_rqst || ext_tx_rqst) quiet = 1'b0;
        end
        chk("holdoff_quiet", int'(quiet), 1);
        chk("holdoff_busy", int'(busy), 1);
    endtask

    task automatic wait_q(input int n, input int limit);
        for (int k = 0; k < limit && q.size() < n; k++) @(negedge clk);
    endtask

    initial begin
        int lat, hi, lo;

        vt[0] = '{1'b0, 6'h05, 1'b1, 6'h05};
        vt[1] = '{1'b0, 6'h2A, 1'b1, 6'h2A};
        vt[2] = '{1'b1, 6'h15, 1'b1, 6'h15};
        vt[3] = '{1'b0, 6'h2A, 1'b0, 6'h00};
        vt[4] = '{1'b1, 6'h3F, 1'b1, 6'h3F};
        vt[5] = '{1'b1, 6'h10, 1'b1, 6'h10};

        // Reset values, then holdoff and the automatic post-init writes.
        host_rx_gain = 6'h20;
        host_tx_gain = 6'h10;
        slave_on     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rx_rqst", int'(ext_rx_rqst), 0);
        chk("rst_tx_rqst", int'(ext_tx_rqst), 0);
        chk("rst_rx_gain", int'(rx_gain), 0);
        chk("rst_tx_gain", int'(tx_gain), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        reset_n = 1'b1;
        check_holdoff();
        wait_q(2, 400);
        chk_q(0, 1'b0, 6'h20);
        chk_q(1, 1'b1, 6'h10);

        // Single-channel changes from IDLE.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            @(negedge clk);
            if (vt[i].is_tx) host_tx_gain = vt[i].code;
            else             host_rx_gain = vt[i].code;
            wait_req(vt[i].is_tx, 60, lat);
            if (vt[i].exp_req) begin
                chk($sformatf("vec%0d_latency", i), lat, STABLE + 2);
                chk($sformatf("vec%0d_gain", i), int'(vt[i].is_tx ? tx_gain : rx_gain),
                    int'(vt[i].exp_gain));
            end else begin
                chk($sformatf("vec%0d_no_request", i), lat, 0);
            end
        end

        // Short glitch on TX must not produce a request.
        wait_idle();
        @(negedge clk);
        host_tx_gain = 6'h11;
        @(negedge clk);
        host_tx_gain = 6'h10;
        wait_req(1'b1, 60, lat);
        chk("glitch_no_request", lat, 0);

        // Both channels change together; force_update during the TX frame.
        wait_idle();
        q.delete();
        @(negedge clk);
        host_rx_gain = 6'h01;
        host_tx_gain = 6'h02;
        for (int k = 0; k < 500 && !(q.size() >= 2 && !sen_n); k++) @(negedge clk);
        chk("force_in_tx_frame", int'(q.size() >= 2 && !sen_n), 1);
        @(negedge clk);
        force_update = 1'b1;
        @(negedge clk);
        force_update = 1'b0;
        wait_q(4, 600);
        wait_idle();
        chk("alt_count", q.size(), 4);
        chk_q(0, 1'b0, 6'h01);
        chk_q(1, 1'b1, 6'h02);
        chk_q(2, 1'b0, 6'h01);
        chk_q(3, 1'b1, 6'h02);

        // Unresponsive slave: request abandoned after TIMEOUT, retried after GAP.
        slave_on = 1'b0;
        @(negedge clk);
        host_rx_gain = 6'h33;
        wait_req(1'b0, 60, lat);
        chk("to_latency", lat, STABLE + 2);
        hi = 1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (!ext_rx_rqst) break;
            hi++;
        end
        chk("to_request_cycles", hi, TIMEOUT);
        chk("to_timeout_err", int'(timeout_err), 1);
        lo = 0;
        for (int k = 0; k < 50 && !ext_rx_rqst; k++) begin
            lo++;
            @(posedge clk);
            #1;
        end
        chk("to_retry_gap", lo, GAP + 1);
        chk("to_retry_gain", int'(rx_gain), 6'h33);
        slave_on = 1'b1;
        wait_idle();

        // Async reset while the TX request is held.
        slave_on = 1'b0;
        @(negedge clk);
        host_tx_gain = 6'h22;
        wait_req(1'b1, 60, lat);
        chk("rr_tx_request", lat, STABLE + 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rr_tx_rqst_dropped", int'(ext_tx_rqst), 0);
        chk("rr_tx_gain", int'(tx_gain), 0);
        chk("rr_busy", int'(busy), 0);
        chk("rr_timeout_err_cleared", int'(timeout_err), 0);
        repeat (3) @(negedge clk);
        q.delete();
        slave_on = 1'b1;
        reset_n  = 1'b1;
        check_holdoff();
        wait_q(2, 400);
        chk_q(0, 1'b0, 6'h33);
        chk_q(1, 1'b1, 6'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
